spi_slave_frame_bridge: RTL and testbench
=========================================

# spi_slave_frame_bridge

System-clock-side companion to the SPI slave core: it takes the slave's parallel receive word and feeds its parallel transmit word. Chip select is synchronised into CLK to find frame boundaries. Each completed frame's receive word goes into a small RX FIFO with a valid/ready stream interface. The next transmit word is accepted from a valid/ready stream and held stable on the slave's transmit input for the whole frame.

## Interface
Parameters:
- PACK_LENGTH, 8, bits per SPI frame; must match the slave core.
- RX_DEPTH, 4, RX FIFO entries; power of two, ≥2.
- TX_IDLE_PATTERN, {PACK_LENGTH{1'b1}}, word presented to the slave when no TX word is loaded.
- SYNC_STAGES, 2, CS synchroniser flops; ≥2.

Ports:
- CLK  in  1  system clock.
- IN_RESET  in  1  asynchronous, active-high reset.
- CS  in  1  SPI chip select, active low, asynchronous to CLK.
- RX_FRAME_DATA  in  PACK_LENGTH  slave core receive word; stable while CS high.
- TX_FRAME_DATA  out  PACK_LENGTH  to slave core transmit input; registered.
- RX_DATA  out  PACK_LENGTH  FIFO head.
- RX_VALID  out  1  FIFO non-empty.
- RX_READY  in  1  consumer pop.
- TX_DATA  in  PACK_LENGTH  next word to send.
- TX_VALID  in  1  producer offers TX_DATA.
- TX_READY  out  1  bridge accepts TX_DATA.
- FRAME_ACTIVE  out  1  synchronised CS is low (state ACTIVE).
- RX_OVERRUN  out  1  one-cycle pulse: frame dropped, FIFO full.

## Operation
- CS passes through SYNC_STAGES flops, all reset to 1, giving cs_s. A one-flop delay gives the edges: fall = frame start, rise = frame end.
- FSM states:
  - SYNC_WAIT: reset state. Goes to IDLE once cs_s = 1. A frame already in progress at reset release is ignored.
  - IDLE: on fall, go to ACTIVE.
  - ACTIVE: on rise, go to CAPTURE.
  - CAPTURE: one cycle. Writes RX_FRAME_DATA into the FIFO, then returns to IDLE.
- RX FIFO write in CAPTURE:
  - If not full, write the word.
  - If full, drop the word, pulse RX_OVERRUN, leave FIFO contents unchanged.
  - If a pop happens in the same cycle while full, the pop frees space first, so the write succeeds.
- RX FIFO pop: occurs when RX_VALID && RX_READY.
  - RX_DATA is a first-word-fall-through head.
  - Pointers wrap modulo RX_DEPTH and carry one extra bit to tell full from empty.
- TX path:
  - One-entry shadow register plus a loaded flag.
  - TX_READY = !loaded && state==IDLE. A handshake loads the shadow and sets loaded.
  - In IDLE, SYNC_WAIT and CAPTURE, TX_FRAME_DATA <= loaded ? shadow : TX_IDLE_PATTERN every cycle.
  - On IDLE→ACTIVE, loaded clears only if it was set before that cycle. A word accepted in the same cycle as the fall is kept for the next frame.
  - TX_FRAME_DATA holds constant throughout ACTIVE.
- FRAME_ACTIVE = (state==ACTIVE).

## Timing
- Reset values:
  - FSM in SYNC_WAIT.
  - FIFO empty, so RX_VALID = 0 and RX_DATA = 0.
  - TX_FRAME_DATA = TX_IDLE_PATTERN.
  - TX_READY = 0, FRAME_ACTIVE = 0, RX_OVERRUN = 0, loaded = 0.
- CS pin fall → FRAME_ACTIVE high after SYNC_STAGES+1 CLK.
- CS pin rise → RX_VALID high after SYNC_STAGES+2 CLK (for an empty FIFO).
- Integration constraints:
  - The master holds CS high for at least SYNC_STAGES+2 CLK between frames.
  - The master leaves at least SYNC_STAGES+1 CLK from CS fall to the first SCLK edge, so that TX_FRAME_DATA is stable.
  - Shorter gaps are outside the spec.
- Asserting IN_RESET mid-frame returns the block to SYNC_WAIT and discards the FIFO and the shadow register.

## Configuration
- SPI_BRIDGE_OVERRUN_CNT_EN defined:
  - Adds output OVERRUN_COUNT [7:0].
  - Saturating count of RX_OVERRUN pulses; resets to 0.
  - Cleared by a one-cycle input OVERRUN_CLR. When a clear and an overrun happen in the same cycle, the result is 1.
- Macro undefined: neither port exists. RX_OVERRUN pulse only.

## Structure
- Package spi_bridge_pkg holds:
  - the FSM state enum: SYNC_WAIT, IDLE, ACTIVE, CAPTURE;
  - the localparam for the pointer width, $clog2(RX_DEPTH)+1.
- Sub-module spi_bridge_rx_fifo: synchronous FWFT FIFO with full/empty flags, instantiated once. The CS synchroniser stays inline.

## Test plan
- Reset with CS low, then three CS toggles → the first partial frame is ignored; words 0x11, 0x22 appear on RX_DATA in order; no RX_OVERRUN.
- Load TX 0xA5 in idle, then run a frame → TX_FRAME_DATA = 0xA5 for the whole CS-low window. The next frame with no load shows 0xFF.
- TX_VALID handshake in the same cycle as the CS-fall detection → the current frame sends 0xFF and the following frame sends the new word.
- Five frames (0x01–0x05) with RX_READY = 0 and RX_DEPTH = 4 → 0x01–0x04 retained, one RX_OVERRUN pulse. With the macro defined, OVERRUN_COUNT = 1.
- FIFO full while CAPTURE coincides with a pop → no overrun; the new word lands at the tail.
- IN_RESET pulsed mid-frame → all outputs return to reset values; FIFO empty; TX_FRAME_DATA = TX_IDLE_PATTERN.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
//------------------------------------------------------------------------------
// spi_bridge_pkg : shared types and sizing helpers for the SPI frame bridge
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_bridge_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    localparam int RX_DEPTH_DEFAULT = 4;
    // Extra MSB distinguishes full from empty when the address bits match.
    localparam int RX_PTR_W = $clog2(RX_DEPTH_DEFAULT) + 1;

    function automatic int rx_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_bridge_rx_fifo.sv
//------------------------------------------------------------------------------
// spi_bridge_rx_fifo : synchronous first-word-fall-through FIFO, full/empty flags
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_bridge_rx_fifo
    import spi_bridge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = RX_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W  = rx_ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_rd;
    logic             w_do_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

    // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

`default_nettype wire

// File: rtl/spi_slave_frame_bridge.sv
//------------------------------------------------------------------------------
// spi_slave_frame_bridge : CLK-side bridge between SPI slave core frame words
// and valid/ready streams. Optional SPI_BRIDGE_OVERRUN_CNT_EN adds OVERRUN_COUNT.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_slave_frame_bridge
    import spi_bridge_pkg::*;
#(
    parameter int                     PACK_LENGTH     = 8,
    parameter int                     RX_DEPTH        = 4,
    parameter logic [PACK_LENGTH-1:0] TX_IDLE_PATTERN = {PACK_LENGTH{1'b1}},
    parameter int                     SYNC_STAGES     = 2
) (
    input  logic                   CLK,
    input  logic                   IN_RESET,
    input  logic                   CS,
    input  logic [PACK_LENGTH-1:0] RX_FRAME_DATA,
    output logic [PACK_LENGTH-1:0] TX_FRAME_DATA,
    output logic [PACK_LENGTH-1:0] RX_DATA,
    output logic                   RX_VALID,
    input  logic                   RX_READY,
    input  logic [PACK_LENGTH-1:0] TX_DATA,
    input  logic                   TX_VALID,
    output logic                   TX_READY,
    output logic                   FRAME_ACTIVE,
    output logic                   RX_OVERRUN
`ifdef SPI_BRIDGE_OVERRUN_CNT_EN
    ,
    input  logic                   OVERRUN_CLR,
    output logic [7:0]             OVERRUN_COUNT
`endif
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_cs_sync;
    logic                     r_cs_d;
    logic [FILL_W-1:0]        r_fill;
    logic                     w_fill_done;
    logic                     w_cs_s;
    logic                     w_cs_fall;
    logic                     w_cs_rise;
    logic                     r_loaded;
    logic [PACK_LENGTH-1:0]   r_shadow;
    logic [PACK_LENGTH-1:0]   r_tx_frame;
    logic                     w_tx_ready;
    logic                     w_tx_hs;
    logic                     w_pop;
    logic                     w_capture;
    logic                     w_fifo_wr;
    logic                     w_overrun;
    logic                     r_rx_overrun;
    logic                     w_full;
    logic                     w_empty;

    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_cs_sync <= '1;
            r_cs_d    <= 1'b1;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_cs_d    <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_cs_fall = r_cs_d && !w_cs_s;
    assign w_cs_rise = !r_cs_d && w_cs_s;

    // The synchroniser resets to 1, so cs_s is only trusted once it has been
    // refilled with real samples; otherwise a frame in progress would look idle.
    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_fill <= '0;
        end else if (!w_fill_done) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    assign w_fill_done = (r_fill == FILL_W'(SYNC_STAGES));

    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_state <= SYNC_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC_WAIT: if (w_fill_done && w_cs_s) w_state_nxt = IDLE;
            IDLE:      if (w_cs_fall)             w_state_nxt = ACTIVE;
            ACTIVE:    if (w_cs_rise)             w_state_nxt = CAPTURE;
            CAPTURE:                              w_state_nxt = IDLE;
            default:                              w_state_nxt = SYNC_WAIT;
        endcase
    end

    assign w_tx_ready = !r_loaded && (r_state == IDLE);
    assign w_tx_hs    = TX_VALID && w_tx_ready;

    // A handshake only happens while unloaded, so it never races the clear.
    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_loaded <= 1'b0;
            r_shadow <= '0;
        end else if (w_tx_hs) begin
            r_loaded <= 1'b1;
            r_shadow <= TX_DATA;
        end else if ((r_state == IDLE) && w_cs_fall) begin
            r_loaded <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_tx_frame <= TX_IDLE_PATTERN;
        end else if (r_state != ACTIVE) begin
            r_tx_frame <= r_loaded ? r_shadow : TX_IDLE_PATTERN;
        end
    end

    assign w_pop     = RX_VALID && RX_READY;
    assign w_capture = (r_state == CAPTURE);
    assign w_fifo_wr = w_capture && (!w_full || w_pop);
    assign w_overrun = w_capture && w_full && !w_pop;

    spi_bridge_rx_fifo #(
        .WIDTH (PACK_LENGTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (CLK),
        .rst       (IN_RESET),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (RX_FRAME_DATA),
        .i_rd_en   (w_pop),
        .o_rd_data (RX_DATA),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= w_overrun;
        end
    end

`ifdef SPI_BRIDGE_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    always_ff @(posedge CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_ovr_cnt <= 8'd0;
        end else if (OVERRUN_CLR) begin
            r_ovr_cnt <= w_overrun ? 8'd1 : 8'd0;
        end else if (w_overrun && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign OVERRUN_COUNT = r_ovr_cnt;
`endif

    assign TX_FRAME_DATA = r_tx_frame;
    assign TX_READY      = w_tx_ready;
    assign RX_VALID      = !w_empty;
    assign FRAME_ACTIVE  = (r_state == ACTIVE);
    assign RX_OVERRUN    = r_rx_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_frame_bridge.sv
//------------------------------------------------------------------------------
// tb_spi_slave_frame_bridge : randomized self-checking bench with a queue model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave_frame_bridge;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       CLK = 1'b0;
    logic       IN_RESET = 1'b1;
    logic       CS = 1'b0;
    logic [7:0] RX_FRAME_DATA = '0;
    logic [7:0] TX_FRAME_DATA;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY = 1'b0;
    logic [7:0] TX_DATA = '0;
    logic       TX_VALID = 1'b0;
    logic       TX_READY;
    logic       FRAME_ACTIVE;
    logic       RX_OVERRUN;
`ifdef SPI_BRIDGE_OVERRUN_CNT_EN
    logic       OVERRUN_CLR = 1'b0;
    logic [7:0] OVERRUN_COUNT;
`endif

    spi_slave_frame_bridge #(
        .PACK_LENGTH     (8),
        .RX_DEPTH        (DEPTH),
        .TX_IDLE_PATTERN (8'hFF),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .CLK           (CLK),
        .IN_RESET      (IN_RESET),
        .CS            (CS),
        .RX_FRAME_DATA (RX_FRAME_DATA),
        .TX_FRAME_DATA (TX_FRAME_DATA),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_READY      (RX_READY),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .FRAME_ACTIVE  (FRAME_ACTIVE),
        .RX_OVERRUN    (RX_OVERRUN)
`ifdef SPI_BRIDGE_OVERRUN_CNT_EN
        ,
        .OVERRUN_CLR   (OVERRUN_CLR),
        .OVERRUN_COUNT (OVERRUN_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] q[$];
    logic [7:0] tx_pend = '0;
    bit         tx_loaded = 1'b0;
    int         ovr_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_rx_valid", RX_VALID, 0);
        chk("rst_rx_data", RX_DATA, 0);
        chk("rst_tx_frame", TX_FRAME_DATA, 8'hFF);
        chk("rst_tx_ready", TX_READY, 0);
        chk("rst_frame_active", FRAME_ACTIVE, 0);
        chk("rst_overrun", RX_OVERRUN, 0);
    endtask

    // Reset asserted with CS low; the frame in progress at release must be ignored.
    task automatic reset_with_partial_frame();
        CS = 1'b0;
        IN_RESET = 1'b1;
        q.delete();
        tx_loaded = 1'b0;
        ovr_total = 0;
        repeat (2) @(negedge CLK);
        chk_reset_values();
        IN_RESET = 1'b0;
        RX_FRAME_DATA = 8'h99;
        repeat (6) @(negedge CLK);
        chk("partial_active", FRAME_ACTIVE, 0);
        CS = 1'b1;
        repeat (8) @(negedge CLK);
        chk("partial_ignored", RX_VALID, 0);
        chk("partial_overrun", RX_OVERRUN, 0);
    endtask

    task automatic load_tx(input logic [7:0] w);
        int i;
        for (i = 0; i < 20 && !TX_READY; i++) @(negedge CLK);
        chk("tx_ready_wait", TX_READY, 1);
        if (TX_READY) begin
            TX_VALID = 1'b1;
            TX_DATA  = w;
            @(negedge CLK);
            TX_VALID = 1'b0;
            tx_pend   = w;
            tx_loaded = 1'b1;
            chk("tx_ready_after_load", TX_READY, 0);
        end
    endtask

    task automatic run_frame(input logic [7:0] rxw, input bit pop_cap,
                             input bit tx_at_fall, input logic [7:0] txw);
        logic [7:0] exp_tx;
        bit         do_pop;
        bit         exp_ovr;
        exp_tx    = tx_loaded ? tx_pend : 8'hFF;
        tx_loaded = 1'b0;
        CS = 1'b0;
        @(negedge CLK);
        chk("tx_window", TX_FRAME_DATA, exp_tx);
        @(negedge CLK);
        chk("pre_active", FRAME_ACTIVE, 0);
        if (tx_at_fall) begin
            chk("tx_ready_at_fall", TX_READY, 1);
            TX_VALID = 1'b1;
            TX_DATA  = txw;
        end
        @(negedge CLK);
        TX_VALID = 1'b0;
        if (tx_at_fall) begin
            tx_pend   = txw;
            tx_loaded = 1'b1;
        end
        chk("frame_active", FRAME_ACTIVE, 1);
        chk("tx_window", TX_FRAME_DATA, exp_tx);
        repeat ($urandom_range(1, 4)) begin
            @(negedge CLK);
            chk("tx_hold", TX_FRAME_DATA, exp_tx);
        end
        RX_FRAME_DATA = rxw;
        CS = 1'b1;
        repeat (2) @(negedge CLK);
        chk("active_till_rise", FRAME_ACTIVE, 1);
        @(negedge CLK);
        chk("capture_inactive", FRAME_ACTIVE, 0);
        do_pop = pop_cap && (q.size() > 0);
        if (do_pop) begin
            chk("pop_at_capture_data", RX_DATA, q[0]);
            RX_READY = 1'b1;
        end
        @(negedge CLK);
        RX_READY = 1'b0;
        if (do_pop) void'(q.pop_front());
        exp_ovr = (q.size() >= DEPTH);
        if (exp_ovr) ovr_total++;
        else q.push_back(rxw);
        chk("overrun_pulse", RX_OVERRUN, exp_ovr);
        chk("rx_valid", RX_VALID, q.size() > 0);
        chk("rx_head", RX_DATA, (q.size() > 0) ? q[0] : 8'h00);
`ifdef SPI_BRIDGE_OVERRUN_CNT_EN
        chk("overrun_count", OVERRUN_COUNT, ovr_total);
`endif
        @(negedge CLK);
        chk("overrun_one_cycle", RX_OVERRUN, 0);
        repeat (SYNC) @(negedge CLK);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 2 * DEPTH) begin
            chk("drain_valid", RX_VALID, 1);
            chk("drain_data", RX_DATA, q[0]);
            RX_READY = 1'b1;
            @(negedge CLK);
            RX_READY = 1'b0;
            void'(q.pop_front());
            guard++;
        end
        chk("drain_empty", RX_VALID, 0);
        chk("drain_empty_data", RX_DATA, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        reset_with_partial_frame();

        run_frame(8'h11, 0, 0, 8'h00);
        run_frame(8'h22, 0, 0, 8'h00);
        drain();

        load_tx(8'hA5);
        run_frame(8'h33, 0, 0, 8'h00);
        run_frame(8'h44, 0, 0, 8'h00);
        drain();

        run_frame(8'h55, 0, 1, 8'h3C);
        run_frame(8'h66, 0, 0, 8'h00);
        drain();

        for (int i = 1; i <= 5; i++) run_frame(8'(i), 0, 0, 8'h00);
        run_frame(8'h06, 1, 0, 8'h00);
        drain();

        for (int i = 0; i < 30; i++) begin
            if (!tx_loaded && $urandom_range(0, 1) == 1) load_tx(8'($urandom));
            run_frame(8'($urandom), $urandom_range(0, 2) == 0,
                      !tx_loaded && $urandom_range(0, 4) == 0, 8'($urandom));
            if ($urandom_range(0, 4) == 0) drain();
        end
        drain();

        run_frame(8'h77, 0, 0, 8'h00);
        load_tx(8'h5A);
        CS = 1'b0;
        repeat (4) @(negedge CLK);
        chk("mid_frame_active", FRAME_ACTIVE, 1);
        reset_with_partial_frame();
        run_frame(8'h88, 0, 0, 8'h00);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
